vga_ball: RTL and testbench



---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_counters.sv | 33 +++
 rtl/vga_ball.sv | 108 ++++++++++
 tb/tb_vga_ball.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing, geometry and type definitions for the VGA bitmap display.
package vga_pkg;

  typedef logic [10:0] hcount_t;
  typedef logic [9:0]  vcount_t;
  typedef logic [14:0] fb_addr_t;

  // Horizontal timing in clk units (two clks per 640-pixel)
  localparam hcount_t HACTIVE = 11'd1280;
  localparam hcount_t HFP     = 11'd32;
  localparam hcount_t HSYNC   = 11'd192;
  localparam hcount_t HBP     = 11'd96;
  localparam hcount_t HTOTAL  = 11'd1600;

  // Vertical timing in lines
  localparam vcount_t VACTIVE = 10'd480;
  localparam vcount_t VFP     = 10'd10;
  localparam vcount_t VSYNC   = 10'd2;
  localparam vcount_t VBP     = 10'd33;
  localparam vcount_t VTOTAL  = 10'd525;

  localparam hcount_t HSYNC_START = HACTIVE + HFP;
  localparam hcount_t HSYNC_END   = HSYNC_START + HSYNC;
  localparam hcount_t HLAST       = HTOTAL - 11'd1;

  localparam vcount_t VSYNC_START = VACTIVE + VFP;
  localparam vcount_t VSYNC_END   = VSYNC_START + VSYNC;
  localparam vcount_t VLAST       = VTOTAL - 10'd1;

  // Framebuffer geometry: 480 rows of 40 words, one bit per hcount column
  localparam fb_addr_t FB_WORDS      = 15'd19200;
  localparam fb_addr_t WORDS_PER_ROW = 15'd40;
  localparam int       FB_DEPTH      = 19200;

  // Word holding the bit for a given scan position
  function automatic fb_addr_t fb_word_addr(input vcount_t row, input hcount_t col);
    return fb_addr_t'(row) * WORDS_PER_ROW + fb_addr_t'(col[10:5]);
  endfunction

endpackage

// File: rtl/vga_counters.sv
// Raster counters and undelayed sync/blank/pixel-clock generation.
module vga_counters
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  output hcount_t hcount,
  output vcount_t vcount,
  output logic    vga_hs,
  output logic    vga_vs,
  output logic    vga_blank_n,
  output logic    vga_clk
);

  // hcount runs every clk; vcount steps when hcount wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == HLAST) begin
      hcount <= '0;
      vcount <= (vcount == VLAST) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign vga_hs      = !((hcount >= HSYNC_START) && (hcount < HSYNC_END));
  assign vga_vs      = !((vcount >= VSYNC_START) && (vcount < VSYNC_END));
  assign vga_blank_n = (hcount < HACTIVE) && (vcount < VACTIVE);
  assign vga_clk     = hcount[0];

endmodule

// File: rtl/vga_ball.sv
// Monochrome bitmap VGA controller: host-written framebuffer scanned at 640x480@60.
// Pixel path: counters -> RAM address (stage 0), RAM data (stage 1), RGB register (stage 2).
module vga_ball
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [14:0] address,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);

  hcount_t hcount;
  vcount_t vcount;
  logic    hs_raw;
  logic    vs_raw;
  logic    active_raw;
  logic    clk_raw;

  vga_counters u_counters (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .vga_hs      (hs_raw),
    .vga_vs      (vs_raw),
    .vga_blank_n (active_raw),
    .vga_clk     (clk_raw)
  );

  logic [31:0] fb_mem [0:FB_DEPTH-1];
  logic [31:0] rd_data;
  fb_addr_t    rd_addr;
  logic        wr_en;

  // Out-of-range addresses are dropped rather than wrapped
  assign wr_en   = chipselect && write && (address < FB_WORDS);
  // Outside the active window the read address is parked at 0
  assign rd_addr = active_raw ? fb_word_addr(vcount, hcount) : '0;

  // Simple dual-port RAM; a same-address read returns the pre-write word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[address] <= writedata;
    end
    rd_data <= fb_mem[rd_addr];
  end

  logic [4:0] bit_sel_d1;
  logic       active_d1;
  logic       hs_d1;
  logic       vs_d1;

  // Stage 1: carry bit index and timing alongside the RAM access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_sel_d1 <= '0;
      active_d1  <= 1'b0;
      hs_d1      <= 1'b1;
      vs_d1      <= 1'b1;
    end else begin
      bit_sel_d1 <= hcount[4:0];
      active_d1  <= active_raw;
      hs_d1      <= hs_raw;
      vs_d1      <= vs_raw;
    end
  end

  logic pixel_q;
  logic blank_n_q;
  logic hs_q;
  logic vs_q;

  // Stage 2: select the bit, gate with active video, register outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_q   <= 1'b0;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      pixel_q   <= rd_data[bit_sel_d1] & active_d1;
      blank_n_q <= active_d1;
      hs_q      <= hs_d1;
      vs_q      <= vs_d1;
    end
  end

  assign VGA_R       = {8{pixel_q}};
  assign VGA_G       = {8{pixel_q}};
  assign VGA_B       = {8{pixel_q}};
  assign VGA_BLANK_n = blank_n_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_SYNC_n  = 1'b0;
  // Pixel clock follows the live counter, not the delayed pipeline
  assign VGA_CLK     = clk_raw;

endmodule

// File: tb/tb_vga_ball.sv
// Scoreboard bench for vga_ball: loads the top rows of the framebuffer while
// in reset, then compares every output clk against a raster model.
module tb_vga_ball;

  localparam int NROWS = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] writedata = '0;
  logic        write = 1'b0;
  logic        chipselect = 1'b0;
  logic [14:0] address = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  vga_ball dut (
    .clk         (clk),
    .reset       (reset),
    .writedata   (writedata),
    .write       (write),
    .chipselect  (chipselect),
    .address     (address),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_n (VGA_BLANK_n),
    .VGA_SYNC_n  (VGA_SYNC_n)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          h;
    int          v;
    logic [27:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] fbm [0:NROWS*40-1];
  int          mh, mv;
  int          n_checks = 0;
  int          n_pass = 0;
  int          whites, row1_whites;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [27:0] model_out(input int h, input int v);
    logic        act, bit_v, hs, vs;
    logic [31:0] w;
    act   = (h < 1280) && (v < 480);
    bit_v = 1'b0;
    if (act && v < NROWS) begin
      w     = fbm[v*40 + h/32];
      bit_v = w[h%32];
    end
    hs = !(h >= 1312 && h < 1504);
    vs = !(v >= 490 && v < 492);
    return {{24{bit_v}}, act, hs, vs, 1'b0};
  endfunction

  function automatic logic [27:0] dut_out();
    return {VGA_R, VGA_G, VGA_B, VGA_BLANK_n, VGA_HS, VGA_VS, VGA_SYNC_n};
  endfunction

  task automatic host_wr(input int a, input logic [31:0] d, input logic cs, input logic w);
    @(negedge clk);
    address    = 15'(a);
    writedata  = d;
    chipselect = cs;
    write      = w;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_rgb"},     {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk({pfx, "_blank_n"}, VGA_BLANK_n, 1'b0);
    chk({pfx, "_hs"},      VGA_HS, 1'b1);
    chk({pfx, "_vs"},      VGA_VS, 1'b1);
    chk({pfx, "_sync_n"},  VGA_SYNC_n, 1'b0);
    chk({pfx, "_vga_clk"}, VGA_CLK, 1'b0);
  endtask

  // Each clk: queue the model output for the pixel now entering the pipeline,
  // then compare the entry two clks old against the DUT.
  task automatic scan(input int ncyc);
    sb_t e;
    logic [27:0] got;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      e.h = mh;
      e.v = mv;
      e.exp = model_out(mh, mv);
      sb_q.push_back(e);
      if (mh == 1599) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      @(negedge clk);
      chk("vga_clk", VGA_CLK, mh[0]);
      if (sb_q.size() >= 2) begin
        e   = sb_q.pop_front();
        got = dut_out();
        chk($sformatf("pix h%0d v%0d", e.h, e.v), got, e.exp);
        if (got[27] && got[3]) begin
          whites++;
          if (e.v == 1) row1_whites++;
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Load rows 0..5 while held in reset; the RAM itself is not reset
    for (int a = 0; a < NROWS*40; a++) begin
      case (a / 40)
        0:       d = 32'hFFFF_FFFF;
        1:       d = (a == 41) ? 32'h0000_0001 : 32'h0;
        2:       d = 32'h5555_5555;
        3:       d = 32'hAAAA_AAAA;
        default: d = 32'h0;
      endcase
      fbm[a] = d;
      host_wr(a, d, 1'b1, 1'b1);
    end
    // None of these may land in the framebuffer
    host_wr(19200, 32'h0000_0000, 1'b1, 1'b1);
    host_wr(19242, 32'hFFFF_FFFF, 1'b1, 1'b1);
    host_wr(32767, 32'hFFFF_FFFF, 1'b1, 1'b1);
    host_wr(43,    32'hFFFF_FFFF, 1'b0, 1'b1);
    host_wr(44,    32'hFFFF_FFFF, 1'b1, 1'b0);
    bus_idle();
    check_reset_vals("rst_after_wr");

    @(negedge clk);
    reset = 1'b1;
    mh = 0;
    mv = 0;
    whites = 0;
    row1_whites = 0;
    scan(3*1600 + 800);

    // Abort mid-line in the checkerboard row; outputs clear without a clk edge
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb_q.delete();
    mh = 0;
    mv = 0;

    for (int a = 0; a < 40; a++) begin
      fbm[a] = 32'h8000_0001;
      host_wr(a, 32'h8000_0001, 1'b1, 1'b1);
    end
    for (int a = 200; a < 240; a++) begin
      fbm[a] = 32'h0000_FFFF;
      host_wr(a, 32'h0000_FFFF, 1'b1, 1'b1);
    end
    bus_idle();

    @(negedge clk);
    reset = 1'b1;
    whites = 0;
    row1_whites = 0;
    scan(NROWS*1600 + 1);
    // row0 80 + row1 1 + row2 640 + row3 640 + row4 0 + row5 640
    chk("white_count", whites, 2001);
    chk("row1_white_count", row1_whites, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
